// File: rtl/dma_io_ctrl.sv
// dma_io_ctrl: block DMA between the device word buffer and memory. Each word takes 2 cycles; start to done_irq is 2*LEN+2 cycles.
// Yields the bus to cpu_bus_req at word boundaries. With DMA_ROUND_ROBIN_EN the CPU gets one grant period, then the DMA takes the bus back.
module dma_io_ctrl #(
  parameter int MEM_AW    = 10,
  parameter int BUF_BASE  = 192,
  parameter int BUF_WORDS = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              cpu_bus_req,
  output logic              cpu_bus_gnt,
  input  logic              io_req,
  output logic              io_ack,
  output logic              io_write,
  output logic [8:0]        io_index,
  input  logic [31:0]       io_data_in,
  output logic [31:0]       io_data_out,
  output logic              io_data_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done_irq,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, WAIT_BUS, PH_A, PH_B, DONE} state_t;

  state_t            state;
  logic [MEM_AW-1:0] mem_base;
  logic [4:0]        len_cfg;
  logic [4:0]        xlen;
  logic [4:0]        idx;
  logic              dir_cfg;
  logic              auto_cfg;
  logic              xdir;
  logic              busy_q;
  logic              err_q;
  logic              cpu_held;
  logic [31:0]       dout_q;

  logic              ctrl_wr;
  logic              abort_wr;
  logic              start_wr;
  logic              trigger;
  logic              bus_go;
  logic              in_phase;
  logic [4:0]        len_sat;
  logic [4:0]        idx_nxt;
  logic [MEM_AW-1:0] word_addr;
  logic [7:0]        buf_idx;
  logic              unused_cfg;

  assign unused_cfg = ^cfg_wdata[31:MEM_AW];

  always_comb begin
    ctrl_wr   = cfg_we && (cfg_addr == 2'd2);
    abort_wr  = ctrl_wr && cfg_wdata[3];
    start_wr  = ctrl_wr && cfg_wdata[0] && !cfg_wdata[3];
    trigger   = start_wr || (auto_cfg && io_req && !abort_wr);
    len_sat   = (32'(len_cfg) > BUF_WORDS) ? 5'(BUF_WORDS) : len_cfg;
    idx_nxt   = idx + 5'd1;
    word_addr = mem_base + MEM_AW'(idx);
    buf_idx   = 8'(BUF_BASE) + {3'b000, idx};
    in_phase  = (state == PH_A) || (state == PH_B);
`ifdef DMA_ROUND_ROBIN_EN
    // once the CPU has had one granted cycle, take the bus back regardless of its request
    bus_go    = !cpu_bus_req || cpu_held;
`else
    bus_go    = !cpu_bus_req;
`endif
  end

  // Bus ownership and device strobes decode straight from the registered state so reset clears them at once.
  assign cpu_bus_gnt = (state == IDLE) || ((state == WAIT_BUS) && !bus_go);
  assign io_index    = in_phase ? {1'b1, buf_idx} : 9'd0;
  assign mem_addr    = in_phase ? word_addr : '0;
  assign mem_we      = (state == PH_B) && !xdir && !abort_wr;
  assign mem_wdata   = ((state == PH_B) && !xdir) ? io_data_in : 32'd0;
  assign io_write    = (state == PH_B) && xdir && !abort_wr;
  assign io_data_oe  = io_write;
  assign io_data_out = dout_q;
  assign io_ack      = (state == DONE);
  assign done_irq    = (state == DONE);
  assign busy        = busy_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_base <= '0;
      len_cfg  <= 5'd0;
      xlen     <= 5'd0;
      idx      <= 5'd0;
      dir_cfg  <= 1'b0;
      auto_cfg <= 1'b0;
      xdir     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cpu_held <= 1'b0;
      dout_q   <= 32'd0;
    end else begin
      cpu_held <= (state == WAIT_BUS) && !bus_go;
      if (abort_wr && (state != IDLE)) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we) begin
              case (cfg_addr)
                2'd0: mem_base <= cfg_wdata[MEM_AW-1:0];
                2'd1: len_cfg  <= cfg_wdata[4:0];
                2'd2: begin
                  dir_cfg  <= cfg_wdata[1];
                  auto_cfg <= cfg_wdata[2];
                end
                default: ;
              endcase
            end
            if (trigger) begin
              xlen   <= len_sat;
              idx    <= 5'd0;
              busy_q <= 1'b1;
              xdir   <= start_wr ? cfg_wdata[1] : dir_cfg;
              state  <= (len_sat == 5'd0) ? DONE : WAIT_BUS;
            end
          end
          WAIT_BUS: begin
            if (bus_go) state <= PH_A;
          end
          PH_A: begin
            if (xdir) dout_q <= mem_rdata;
            state <= PH_B;
          end
          PH_B: begin
            idx <= idx_nxt;
            if (idx_nxt == xlen)  state <= DONE;
            else if (cpu_bus_req) state <= WAIT_BUS;
            else                  state <= PH_A;
          end
          DONE: begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_io_ctrl.sv
// Directed bench for dma_io_ctrl. Device and memory models feed a write scoreboard that is checked on every mem_we or io_write cycle.
module tb_dma_io_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        cpu_bus_req = 1'b0;
  logic        cpu_bus_gnt;
  logic        io_req = 1'b0;
  logic        io_ack, io_write, io_data_oe;
  logic [8:0]  io_index;
  logic [31:0] io_data_in, io_data_out;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, done_irq, err;

  logic [31:0] mem [1024];
  logic [31:0] dev_buf [256];

  typedef struct packed {
    logic        dev;
    logic [9:0]  maddr;
    logic [8:0]  ioidx;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, ack_cnt = 0, we_cnt = 0, wr_cnt = 0;
  int t0, d0, a0, w0, ack_at;
  logic got;

  dma_io_ctrl #(.MEM_AW(10), .BUF_BASE(192), .BUF_WORDS(31)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cpu_bus_req(cpu_bus_req), .cpu_bus_gnt(cpu_bus_gnt), .io_req(io_req), .io_ack(io_ack),
    .io_write(io_write), .io_index(io_index), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_data_oe(io_data_oe), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done_irq(done_irq), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata  = mem[mem_addr];
  assign io_data_in = dev_buf[io_index[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic dev, input logic [9:0] ma, input logic [8:0] ix, input logic [31:0] d);
    exp_t e;
    e.dev = dev; e.maddr = ma; e.ioidx = ix; e.data = d;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt != base), 64'd1);
  endtask

  // Memory and device models plus scoreboard: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we || io_write || io_data_oe) begin
        chk("bus_exclusive", 64'(cpu_bus_gnt), 64'd0);
        chk("oe_matches_write", 64'(io_data_oe), 64'(io_write));
      end
      if (mem_we || io_write) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          if (mem_we) begin
            chk("mem_kind", 64'(mon_e.dev), 64'd0);
            chk("mem_addr", 64'(mem_addr), 64'(mon_e.maddr));
            chk("mem_io_index", 64'(io_index), 64'(mon_e.ioidx));
            chk("mem_wdata", 64'(mem_wdata), 64'(mon_e.data));
          end else begin
            chk("dev_kind", 64'(mon_e.dev), 64'd1);
            chk("dev_io_index", 64'(io_index), 64'(mon_e.ioidx));
            chk("dev_data", 64'(io_data_out), 64'(mon_e.data));
          end
        end
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          we_cnt++;
        end
        if (io_write) begin
          dev_buf[io_index[7:0]] = io_data_out;
          wr_cnt++;
        end
      end
      if (done_irq) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (io_ack) ack_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) dev_buf[i] = 32'd0;

    // reset state
    @(negedge clk);
    chk("rst_gnt", 64'(cpu_bus_gnt), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({io_ack, io_write, io_data_oe, mem_we, done_irq, err}), 64'd0);
    chk("rst_io_index", 64'(io_index), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);

    // device -> memory, 3 words
    for (int i = 0; i < 3; i++) begin
      dev_buf[8'(8'hC0 + i)] = 32'hA + i;
      push_exp(1'b0, 10'(10'h040 + i), 9'(9'h1C0 + i), 32'hA + i);
    end
    cfg_write(2'd0, 32'h040);
    cfg_write(2'd1, 32'd3);
    d0 = done_cnt; t0 = cyc;
    cfg_write(2'd2, 32'h1);
    wait_done(d0, 30);
    chk("t1_latency", 64'(done_cyc - t0), 64'd8);
    chk("t1_mem40", 64'(mem[10'h040]), 64'hA);
    chk("t1_mem41", 64'(mem[10'h041]), 64'hB);
    chk("t1_mem42", 64'(mem[10'h042]), 64'hC);
    chk("t1_sb_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("t1_idle_after", 64'({busy, cpu_bus_gnt}), 64'b01);
    @(posedge clk); #1;

    // memory -> device, 2 words
    mem[10'h010] = 32'h55;
    mem[10'h011] = 32'h66;
    push_exp(1'b1, 10'd0, 9'h1C0, 32'h55);
    push_exp(1'b1, 10'd0, 9'h1C1, 32'h66);
    cfg_write(2'd0, 32'h010);
    cfg_write(2'd1, 32'd2);
    d0 = done_cnt; w0 = wr_cnt; t0 = cyc;
    cfg_write(2'd2, 32'h3);
    wait_done(d0, 30);
    chk("t2_latency", 64'(done_cyc - t0), 64'd6);
    chk("t2_dev_c0", 64'(dev_buf[8'hC0]), 64'h55);
    chk("t2_dev_c1", 64'(dev_buf[8'hC1]), 64'h66);
    chk("t2_write_cycles", 64'(wr_cnt - w0), 64'd2);

    // auto-start on io_req with LEN=0
    cfg_write(2'd1, 32'd0);
    cfg_write(2'd2, 32'h4);
    d0 = done_cnt; a0 = ack_cnt; w0 = we_cnt; t0 = cyc;
    io_req = 1'b1;
    got = 1'b0; ack_at = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (io_ack) begin
        got = 1'b1; ack_at = cyc; io_req = 1'b0;
        break;
      end
    end
    io_req = 1'b0;
    cycles(4);
    chk("t3_ack_seen", 64'(got), 64'd1);
    chk("t3_ack_cycle", 64'(ack_at - t0), 64'd1);
    chk("t3_ack_once", 64'(ack_cnt - a0), 64'd1);
    chk("t3_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t3_no_mem_we", 64'(we_cnt - w0), 64'd0);
    cfg_write(2'd2, 32'h0);

    // 5 words with the CPU taking the bus after word 2 for 4 cycles
    for (int i = 0; i < 5; i++) begin
      dev_buf[8'(8'hC0 + i)] = 32'h100 + i;
      push_exp(1'b0, 10'(10'h100 + i), 9'(9'h1C0 + i), 32'h100 + i);
    end
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'd5);
    d0 = done_cnt; t0 = cyc;
    cfg_write(2'd2, 32'h1);
    cycles(4);
    cpu_bus_req = 1'b1;
    cycles(2);
    @(negedge clk);
`ifdef DMA_ROUND_ROBIN_EN
    chk("t4_stall_gnt", 64'({busy, cpu_bus_gnt}), 64'b10);
`else
    chk("t4_stall_gnt", 64'({busy, cpu_bus_gnt}), 64'b11);
`endif
    chk("t4_stall_index", 64'(io_index), 64'd0);
    @(posedge clk); #1;
    cycles(1);
    cpu_bus_req = 1'b0;
    wait_done(d0, 40);
`ifdef DMA_ROUND_ROBIN_EN
    chk("t4_latency", 64'(done_cyc - t0), 64'd14);
`else
    chk("t4_latency", 64'(done_cyc - t0), 64'd16);
`endif
    chk("t4_mem102", 64'(mem[10'h102]), 64'h102);
    chk("t4_mem104", 64'(mem[10'h104]), 64'h104);
    chk("t4_sb_drained", 64'(sb.size()), 64'd0);

    // abort after the first word of 4
    for (int i = 0; i < 4; i++) begin
      mem[10'(10'h200 + i)] = 32'hDEAD_0000 + i;
      dev_buf[8'(8'hC0 + i)] = 32'h200 + i;
    end
    push_exp(1'b0, 10'h200, 9'h1C0, 32'h200);
    cfg_write(2'd0, 32'h200);
    cfg_write(2'd1, 32'd4);
    d0 = done_cnt;
    cfg_write(2'd2, 32'h1);
    cycles(3);
    cfg_write(2'd2, 32'h8);
    @(negedge clk);
    chk("t5_abort_state", 64'({busy, err, cpu_bus_gnt}), 64'b011);
    chk("t5_abort_index", 64'(io_index), 64'd0);
    @(posedge clk); #1;
    cycles(5);
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_mem200", 64'(mem[10'h200]), 64'h200);
    chk("t5_mem201", 64'(mem[10'h201]), 64'hDEAD_0001);
    chk("t5_sb_drained", 64'(sb.size()), 64'd0);

    // start and abort in the same write
    cfg_write(2'd2, 32'h9);
    @(negedge clk);
    chk("t5_start_abort", 64'({busy, err, cpu_bus_gnt}), 64'b011);
    @(posedge clk); #1;

    // reset in the middle of a memory -> device transfer
    push_exp(1'b1, 10'd0, 9'h1C0, 32'h55);
    cfg_write(2'd0, 32'h010);
    cfg_write(2'd1, 32'd4);
    cfg_write(2'd2, 32'h3);
    cycles(3);
    chk("t6_pre_reset", 64'({busy, io_index, io_data_out}), {23'd0, 1'b1, 9'h1C1, 32'h55});
    rst = 1'b1;
    #1;
    chk("t6_rst_index", 64'(io_index), 64'd0);
    chk("t6_rst_maddr", 64'(mem_addr), 64'd0);
    chk("t6_rst_dout", 64'(io_data_out), 64'd0);
    chk("t6_rst_flags", 64'({cpu_bus_gnt, busy, err, io_write, io_data_oe, mem_we}), 64'b100000);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    chk("t6_sb_drained", 64'(sb.size()), 64'd0);

    // CPU requests the bus throughout a 4-word transfer
    for (int i = 0; i < 4; i++) dev_buf[8'(8'hC0 + i)] = 32'h300 + i;
`ifdef DMA_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) push_exp(1'b0, 10'(10'h300 + i), 9'(9'h1C0 + i), 32'h300 + i);
`endif
    cpu_bus_req = 1'b1;
    cfg_write(2'd0, 32'h300);
    cfg_write(2'd1, 32'd4);
    d0 = done_cnt; t0 = cyc;
    cfg_write(2'd2, 32'h1);
`ifdef DMA_ROUND_ROBIN_EN
    wait_done(d0, 60);
    chk("t7_latency", 64'(done_cyc - t0), 64'd17);
    chk("t7_mem303", 64'(mem[10'h303]), 64'h303);
    chk("t7_sb_drained", 64'(sb.size()), 64'd0);
`else
    cycles(40);
    chk("t7_starved_no_done", 64'(done_cnt - d0), 64'd0);
    @(negedge clk);
    chk("t7_starved_state", 64'({busy, cpu_bus_gnt}), 64'b11);
    @(posedge clk); #1;
    cfg_write(2'd2, 32'h8);
`endif
    cpu_bus_req = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("t7_final_idle", 64'({busy, cpu_bus_gnt}), 64'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
